// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Hazard and forwarding controller for the in-order integer pipeline.
//   It keeps a shift register of in-flight writers (stage 0 = EX, up to
//   NUM_STAGES-1). For the instruction in ID it raises a combinational stall
//   on a not-yet-ready producer. It also registers the forwarding selects
//   used by that instruction during its EX cycle.
//
//   Optional feature macro: HAZARD_ZERO_REG_EN
//     defined   -> register index 0 never matches (no stall/forward on $zero)
//     undefined -> index 0 is tracked like any other register
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   id_valid                ID holds a real instruction
//   id_rs/id_rt             source indices, id_rs_used/id_rt_used qualify them
//   id_rd, id_wr_en         destination and its write enable
//   id_lat                  result latency after EX (0 behaves as 1)
//   ext_stall               freeze the tracked pipeline
//   flush                   squash ID and the stage-0 entry on advance
//   stall                   hold PC/IF-ID, bubble into EX (combinational)
//   fwd_a/fwd_b             registered forward selects (0 = register file)
//   stall_cnt               saturating hazard-stall cycle counter
// ---------------------------------------------------------------------------

// Per-stage comparator: one instance per tracked stage.
module phc_stage_match #(
    parameter int ADDR_W = 5,
    parameter int LAT_W  = 3,
    parameter int STAGE  = 0
) (
    input  logic              i_vld,
    input  logic [ADDR_W-1:0] i_rd,
    input  logic              i_wr_en,
    input  logic [LAT_W-1:0]  i_lat,
    input  logic [ADDR_W-1:0] i_rs,
    input  logic              i_rs_used,
    input  logic [ADDR_W-1:0] i_rt,
    input  logic              i_rt_used,
    output logic              o_hz_rs,
    output logic              o_hz_rt,
    output logic              o_rdy_rs,
    output logic              o_rdy_rt
);
    // Distance from this stage to the consumer's EX cycle.
    localparam logic [LAT_W:0] K = (LAT_W+1)'(STAGE + 1);

    logic w_trk;
    logic w_hit_rs;
    logic w_hit_rt;
    logic w_late;

`ifdef HAZARD_ZERO_REG_EN
    assign w_trk = |i_rd;
`else
    assign w_trk = 1'b1;
`endif

    assign w_hit_rs = i_vld & i_wr_en & w_trk & i_rs_used & (i_rd == i_rs);
    assign w_hit_rt = i_vld & i_wr_en & w_trk & i_rt_used & (i_rd == i_rt);
    assign w_late   = K < {1'b0, i_lat};

    assign o_hz_rs  = w_hit_rs & w_late;
    assign o_hz_rt  = w_hit_rt & w_late;
    assign o_rdy_rs = w_hit_rs & ~w_late;
    assign o_rdy_rt = w_hit_rt & ~w_late;
endmodule

module pipe_hazard_ctrl #(
    parameter int ADDR_W     = 5,
    parameter int NUM_STAGES = 3,
    parameter int LAT_W      = 3,
    parameter int SEL_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_rs_used,
    input  logic              id_rt_used,
    input  logic [ADDR_W-1:0] id_rd,
    input  logic              id_wr_en,
    input  logic [LAT_W-1:0]  id_lat,
    input  logic              ext_stall,
    input  logic              flush,
    output logic              stall,
    output logic [SEL_W-1:0]  fwd_a,
    output logic [SEL_W-1:0]  fwd_b,
    output logic [15:0]       stall_cnt
);
    // Tracked writer entries, index = stage.
    logic [NUM_STAGES-1:0]             r_vld;
    logic [NUM_STAGES-1:0][ADDR_W-1:0] r_rd;
    logic [NUM_STAGES-1:0]             r_wr;
    logic [NUM_STAGES-1:0][LAT_W-1:0]  r_lat;

    logic [SEL_W-1:0] r_fwd_a;
    logic [SEL_W-1:0] r_fwd_b;
    logic [15:0]      r_stall_cnt;

    logic [NUM_STAGES-1:0] w_hz_rs;
    logic [NUM_STAGES-1:0] w_hz_rt;
    logic [NUM_STAGES-1:0] w_rdy_rs;
    logic [NUM_STAGES-1:0] w_rdy_rt;

    logic             w_hz;
    logic             w_adv;
    logic             w_load;
    logic [LAT_W-1:0] w_lat;
    logic [SEL_W-1:0] w_sel_a;
    logic [SEL_W-1:0] w_sel_b;

    genvar g;
    generate
        for (g = 0; g < NUM_STAGES; g++) begin : g_stage
            phc_stage_match #(
                .ADDR_W (ADDR_W),
                .LAT_W  (LAT_W),
                .STAGE  (g)
            ) u_match (
                .i_vld     (r_vld[g]),
                .i_rd      (r_rd[g]),
                .i_wr_en   (r_wr[g]),
                .i_lat     (r_lat[g]),
                .i_rs      (id_rs),
                .i_rs_used (id_rs_used),
                .i_rt      (id_rt),
                .i_rt_used (id_rt_used),
                .o_hz_rs   (w_hz_rs[g]),
                .o_hz_rt   (w_hz_rt[g]),
                .o_rdy_rs  (w_rdy_rs[g]),
                .o_rdy_rt  (w_rdy_rt[g])
            );
        end
    endgenerate

    assign w_hz   = id_valid & (|w_hz_rs | |w_hz_rt);
    assign w_adv  = ~ext_stall;
    assign w_load = id_valid & ~w_hz & ~flush;
    assign w_lat  = (id_lat == '0) ? LAT_W'(1) : id_lat;

    // Youngest ready producer wins. The last stage is excluded: that writer
    // has already reached the write-through register file.
    always_comb begin
        w_sel_a = '0;
        w_sel_b = '0;
        for (int s = NUM_STAGES - 1; s >= 0; s--) begin
            if (s <= NUM_STAGES - 2 && w_rdy_rs[s]) w_sel_a = SEL_W'(s + 1);
            if (s <= NUM_STAGES - 2 && w_rdy_rt[s]) w_sel_b = SEL_W'(s + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld   <= '0;
            r_rd    <= '0;
            r_wr    <= '0;
            r_lat   <= '0;
            r_fwd_a <= '0;
            r_fwd_b <= '0;
        end else if (w_adv) begin
            for (int s = NUM_STAGES - 1; s > 0; s--) begin
                r_vld[s] <= r_vld[s-1];
                r_rd[s]  <= r_rd[s-1];
                r_wr[s]  <= r_wr[s-1];
                r_lat[s] <= r_lat[s-1];
            end
            // Wrong-path squash also kills the stage-0 entry as it moves on.
            r_vld[1] <= r_vld[0] & ~flush;
            r_vld[0] <= w_load;
            r_rd[0]  <= id_rd;
            r_wr[0]  <= id_wr_en;
            r_lat[0] <= w_lat;
            r_fwd_a  <= w_load ? w_sel_a : '0;
            r_fwd_b  <= w_load ? w_sel_b : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cnt <= '0;
        end else if (w_hz && w_adv && r_stall_cnt != 16'hFFFF) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stall     = w_hz | ext_stall;
    assign fwd_a     = r_fwd_a;
    assign fwd_b     = r_fwd_b;
    assign stall_cnt = r_stall_cnt;
endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Parametrised hazard and forwarding controller for the in-order integer pipeline. It tracks in-flight register writers across NUM_STAGES stages after decode. For the instruction in ID it decides whether to stall (load-use and any multi-cycle latency), and it registers forwarding selects for that instruction's EX cycle. It generalises the fixed EX/MEM/WB load-use check with per-instruction result latency, configurable depth, external freeze and a wrong-path squash.

## Interface
Parameters:
- ADDR_W, 5, register index width
- NUM_STAGES, 3, tracked stages after ID (stage 0 = EX); legal 2..8
- LAT_W, 3, width of id_lat and per-entry countdown; must hold NUM_STAGES
- SEL_W, 3, width of forward selects; must hold NUM_STAGES-1

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rs, id_rt  in  ADDR_W  source register indices
- id_rs_used, id_rt_used  in  1  source actually read
- id_rd  in  ADDR_W  destination index
- id_wr_en  in  1  instruction writes id_rd
- id_lat  in  LAT_W  stages after EX until result is forwardable (ALU=1, load=2); 0 is treated as 1
- ext_stall  in  1  freeze whole tracked pipeline (memory wait)
- flush  in  1  squash ID instruction and stage-0 entry (wrong path)
- stall  out  1  hold PC and IF/ID, insert bubble into EX
- fwd_a, fwd_b  out  SEL_W  registered; 0 = register file, k = stage-k pipeline register
- stall_cnt  out  16  saturating count of hazard-stall cycles

## Operation
- Each stage s holds an entry: valid, rd, wr_en, lat.
- Match(s, r): valid & wr_en & rd==r & source used.
- Hazard: a Match at stage s with s+1 < lat means the data is not ready when the consumer reaches EX.
- hz = id_valid & (hazard on rs or rt).
- stall = hz | ext_stall (combinational).
- Advance occurs when ext_stall==0. Entries shift s to s+1. The entry leaving the last stage is dropped (it has written the register file, which is write-through).
- Stage 0 load on advance:
  - the ID instruction if id_valid & ~hz & ~flush;
  - otherwise a bubble (valid=0).
- flush on advance also kills the entry moving from stage 0 to stage 1 (it becomes valid=0). flush without advance has no effect on entries.
- Forward select for rs (likewise rt), computed on advance:
  - Take the youngest (lowest s, s ≤ NUM_STAGES-2) Match with s+1 ≥ lat.
  - fwd_a ← s+1; if no match, 0.
  - A bubble loads 0.
  - fwd holds when not advancing.
- stall_cnt increments on every cycle with hz & ~ext_stall, saturating at 16'hFFFF.

## Timing
- Reset, asynchronous on rst_n low:
  - all entries valid=0;
  - fwd_a=fwd_b=0;
  - stall_cnt=0;
  - stall = ext_stall only.
- stall: zero-cycle combinational path from ID inputs.
- fwd_a/fwd_b: one-cycle latency; valid during the consumer's EX cycle.
- Load-use (lat=2) immediately followed by a consumer:
  - exactly 1 stall cycle;
  - then fwd=2.
- lat=L directly followed by a consumer: L-1 stall cycles.
- Simultaneous hz and flush: the bubble goes to stage 0; stall is still asserted for that cycle.
- Simultaneous ext_stall and flush: nothing changes; flush must be held until the advance.
- Reset mid-stall: all hazards vanish; stall deasserts on the next evaluation.

## Configuration
- HAZARD_ZERO_REG_EN:
  - Defined: index 0 never matches, so no stalls or forwards from $zero.
  - Undefined: index 0 is tracked like any other register.

## Test plan
- Load-use, lat=2, rd=5, then rs=5: stall=1 for one cycle; next EX cycle fwd_a=2; stall_cnt=1.
- ALU rd=3 lat=1, then rs=3, rt=3: no stall; fwd_a=fwd_b=1. Same with one independent instruction between: fwd=2.
- Two writers to r7, ALU then ALU, then reader: youngest wins, fwd_a=1.
- Reader of r0 behind writer rd=0: with HAZARD_ZERO_REG_EN, fwd=0 and no stall; without it, fwd_a=1.
- ext_stall held 3 cycles during a load-use: entries and fwd frozen; stall_cnt unchanged; after release, 1 hazard stall then fwd=2.
- flush with a load in stage 0 and a reader of that load in ID: both squashed; next cycle stall=0 and fwd=0. rst_n low mid-stall: stall=0 and stall_cnt=0 asynchronously.
